// File: rtl/aib_axi_lite_leader_link_if.sv
// ----------------------------------------------------------------------------
// aib_axi_lite_leader_link_if
// AXI-Lite user-side bundle for the AIB leader link.
//   slave  modport : the link block (accepts AW/W/AR, returns B/R)
//   master modport : the user / requester driving the link block
// Signals: user_aw{addr,valid,ready}, user_w{data,strb,valid,ready},
//          user_ar{addr,valid,ready}, user_b{resp,valid,ready},
//          user_r{data,resp,valid,ready}
// ----------------------------------------------------------------------------
interface aib_axi_lite_leader_link_if;
    logic [31:0] user_awaddr;
    logic        user_awvalid;
    logic        user_awready;
    logic [31:0] user_wdata;
    logic [3:0]  user_wstrb;
    logic        user_wvalid;
    logic        user_wready;
    logic [31:0] user_araddr;
    logic        user_arvalid;
    logic        user_arready;
    logic [1:0]  user_bresp;
    logic        user_bvalid;
    logic        user_bready;
    logic [31:0] user_rdata;
    logic [1:0]  user_rresp;
    logic        user_rvalid;
    logic        user_rready;

    modport slave (
        input  user_awaddr, user_awvalid, output user_awready,
        input  user_wdata, user_wstrb, user_wvalid, output user_wready,
        input  user_araddr, user_arvalid, output user_arready,
        output user_bresp, user_bvalid, input user_bready,
        output user_rdata, user_rresp, user_rvalid, input user_rready
    );

    modport master (
        output user_awaddr, user_awvalid, input user_awready,
        output user_wdata, user_wstrb, user_wvalid, input user_wready,
        output user_araddr, user_arvalid, input user_arready,
        input  user_bresp, user_bvalid, output user_bready,
        input  user_rdata, user_rresp, user_rvalid, output user_rready
    );
endinterface

// File: rtl/aib_axi_lite_leader_link.sv
// ----------------------------------------------------------------------------
// aib_axi_lite_leader_link
// Credit-based AXI-Lite leader over an 80-bit AIB PHY word.
//   clk_wr / rst_wr        : single clock, async active-high reset
//   tx_online / rx_online  : PHY link-up per direction
//   init_aw/ar_credit      : follower credit grants (reloaded while offline)
//   user (slave modport)   : AXI-Lite request/response ports
//   tx_phy0 (registered)   : outgoing word; rx_phy0 : incoming word
//   proto_err / parity_err : sticky error flags
// Optional feature: define AIB_AXI_LEADER_PARITY_EN for even parity on
// bit 76 of tx words and parity checking/dropping of rx words.
// ----------------------------------------------------------------------------
module aib_axi_lite_leader_link_fifo #(
    parameter int unsigned W     = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_push = push_i & ~full_o;   // push into a full FIFO is dropped
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= nxt(wr_q);
            if (do_pop)  rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

module aib_axi_lite_leader_link #(
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic                        clk_wr,
    input  logic                        rst_wr,
    input  logic                        tx_online,
    input  logic                        rx_online,
    input  logic [7:0]                  init_aw_credit,
    input  logic [7:0]                  init_ar_credit,
    aib_axi_lite_leader_link_if.slave   user,
    output logic [79:0]                 tx_phy0,
    input  logic [79:0]                 rx_phy0,
    output logic                        proto_err,
    output logic                        parity_err
);
    typedef enum logic {OFFLINE = 1'b0, ONLINE = 1'b1} link_state_e;

    link_state_e state_q;
    logic [7:0]  aw_cnt_q, ar_cnt_q;
    logic        prio_wr_q;              // 1: write side wins the next tie
    logic [3:0]  racc_q, bacc_q;
    logic [79:0] tx_q, tx_d;
    logic        proto_err_q;

    logic online, link_up, gate;
    logic w_elig, r_elig, grant_w, grant_r, send_cr;
    logic rx_par_ok, rx_acc, b_push, r_push, b_pop, r_pop;
    logic b_empty, b_full, r_empty, r_full;
    logic [1:0]  rx_type;
    logic [3:0]  ret_aw, ret_ar;
    logic [8:0]  aw_sum, ar_sum;
    logic        aw_sat, ar_sat, proto_set;

    assign link_up = tx_online & rx_online;
    assign online  = (state_q == ONLINE);
    assign gate    = online & tx_online;

    assign w_elig  = gate & user.user_awvalid & user.user_wvalid & (aw_cnt_q != '0);
    assign r_elig  = gate & user.user_arvalid & (ar_cnt_q != '0);
    assign grant_w = w_elig & (~r_elig | prio_wr_q);
    assign grant_r = r_elig & ~grant_w;

    assign user.user_awready = grant_w;
    assign user.user_wready  = grant_w;
    assign user.user_arready = grant_r;

`ifdef AIB_AXI_LEADER_PARITY_EN
    logic parity_err_q;
    assign rx_par_ok  = ~^rx_phy0;
    assign parity_err = parity_err_q;
    logic unused_rx;
    assign unused_rx = ^{rx_phy0[73:72], rx_phy0[39:8]};
`else
    assign rx_par_ok  = 1'b1;
    assign parity_err = 1'b0;
    logic unused_rx;
    assign unused_rx = ^{rx_phy0[76], rx_phy0[73:72], rx_phy0[39:8]};
`endif

    // rx is only looked at while ONLINE; bad parity drops the word and its credits
    assign rx_acc  = online & rx_phy0[79] & rx_par_ok;
    assign rx_type = rx_phy0[78:77];
    assign b_push  = rx_acc & (rx_type == 2'b01);
    assign r_push  = rx_acc & (rx_type == 2'b10);
    assign ret_aw  = rx_acc ? rx_phy0[3:0] : '0;
    assign ret_ar  = rx_acc ? rx_phy0[7:4] : '0;

    assign user.user_bvalid = ~b_empty;
    assign user.user_rvalid = ~r_empty;
    assign b_pop = user.user_bvalid & user.user_bready;
    assign r_pop = user.user_rvalid & user.user_rready;

    aib_axi_lite_leader_link_fifo #(.W(2), .DEPTH(RSP_DEPTH)) u_bfifo (
        .clk_i(clk_wr), .rst_i(rst_wr), .clr_i(~online),
        .push_i(b_push), .din_i(rx_phy0[75:74]), .pop_i(b_pop),
        .dout_o(user.user_bresp), .empty_o(b_empty), .full_o(b_full)
    );

    aib_axi_lite_leader_link_fifo #(.W(34), .DEPTH(RSP_DEPTH)) u_rfifo (
        .clk_i(clk_wr), .rst_i(rst_wr), .clr_i(~online),
        .push_i(r_push), .din_i({rx_phy0[71:40], rx_phy0[75:74]}), .pop_i(r_pop),
        .dout_o({user.user_rdata, user.user_rresp}), .empty_o(r_empty), .full_o(r_full)
    );

    // 9-bit sums so an over-return is visible before saturation
    assign aw_sum = {1'b0, aw_cnt_q} + {5'b0, ret_aw} - {8'b0, grant_w};
    assign ar_sum = {1'b0, ar_cnt_q} + {5'b0, ret_ar} - {8'b0, grant_r};
    assign aw_sat = aw_sum > {1'b0, init_aw_credit};
    assign ar_sat = ar_sum > {1'b0, init_ar_credit};

    assign proto_set = (online & (aw_sat | ar_sat)) | (b_push & b_full) |
                       (r_push & r_full) | (rx_acc & (rx_type == 2'b11));

    assign send_cr = gate & ~grant_w & ~grant_r & ((racc_q != '0) | (bacc_q != '0));

    always_comb begin
        tx_d = '0;
        if (grant_w | grant_r | send_cr) begin
            tx_d[79]    = 1'b1;
            tx_d[78:77] = grant_w ? 2'b01 : (grant_r ? 2'b10 : 2'b00);
            tx_d[7:4]   = racc_q;
            tx_d[3:0]   = bacc_q;
        end
        if (grant_w) begin
            tx_d[75:72] = user.user_wstrb;
            tx_d[71:40] = user.user_awaddr;
            tx_d[39:8]  = user.user_wdata;
        end
        if (grant_r) tx_d[71:40] = user.user_araddr;
`ifdef AIB_AXI_LEADER_PARITY_EN
        tx_d[76] = ^tx_d;                 // bit 76 is still 0 here
`endif
    end

    assign tx_phy0   = tx_q;
    assign proto_err = proto_err_q;

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            state_q     <= OFFLINE;
            aw_cnt_q    <= '0;
            ar_cnt_q    <= '0;
            prio_wr_q   <= 1'b1;
            racc_q      <= '0;
            bacc_q      <= '0;
            tx_q        <= '0;
            proto_err_q <= 1'b0;
`ifdef AIB_AXI_LEADER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            proto_err_q <= proto_err_q | proto_set;
`ifdef AIB_AXI_LEADER_PARITY_EN
            parity_err_q <= parity_err_q | (online & rx_phy0[79] & ~rx_par_ok);
`endif
            if (grant_w)      prio_wr_q <= 1'b0;
            else if (grant_r) prio_wr_q <= 1'b1;
            case (state_q)
                OFFLINE: begin
                    aw_cnt_q <= init_aw_credit;
                    ar_cnt_q <= init_ar_credit;
                    racc_q   <= '0;
                    bacc_q   <= '0;
                    tx_q     <= '0;
                    if (link_up) state_q <= ONLINE;
                end
                default: begin
                    aw_cnt_q <= aw_sat ? init_aw_credit : aw_sum[7:0];
                    ar_cnt_q <= ar_sat ? init_ar_credit : ar_sum[7:0];
                    // any sent word carries the accumulator; a same-cycle pop rolls into the next
                    racc_q   <= tx_d[79] ? {3'b0, r_pop} : racc_q + {3'b0, r_pop};
                    bacc_q   <= tx_d[79] ? {3'b0, b_pop} : bacc_q + {3'b0, b_pop};
                    tx_q     <= tx_d;
                    if (!link_up) state_q <= OFFLINE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aib_axi_lite_leader_link.sv
module tb_aib_axi_lite_leader_link;
    localparam int unsigned DEPTH = 4;

    logic        clk_wr = 1'b0;
    logic        rst_wr;
    logic        tx_online, rx_online;
    logic [7:0]  init_aw_credit, init_ar_credit;
    logic [79:0] tx_phy0, rx_phy0;
    logic        proto_err, parity_err;

    aib_axi_lite_leader_link_if uif ();

    aib_axi_lite_leader_link #(.RSP_DEPTH(DEPTH)) dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr),
        .tx_online(tx_online), .rx_online(rx_online),
        .init_aw_credit(init_aw_credit), .init_ar_credit(init_ar_credit),
        .user(uif), .tx_phy0(tx_phy0), .rx_phy0(rx_phy0),
        .proto_err(proto_err), .parity_err(parity_err)
    );

    always #5 clk_wr = ~clk_wr;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic        m_on, m_prio_wr, m_perr, m_parerr;
    int          m_aw, m_ar, m_racc, m_bacc;
    logic [33:0] rq [$];
    logic [1:0]  bq [$];
    logic [79:0] txq [$];
    int          owed_aw, owed_ar, owed_b, owed_r;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_prio_wr = 1; m_perr = 0; m_parerr = 0;
        m_aw = 0; m_ar = 0; m_racc = 0; m_bacc = 0;
        rq.delete(); bq.delete(); txq.delete();
        owed_aw = 0; owed_ar = 0; owed_b = 0; owed_r = 0;
    endtask

    function automatic logic [79:0] rxw(input logic [1:0] typ, input logic [1:0] resp,
                                        input logic [31:0] data, input logic [3:0] ar_ret,
                                        input logic [3:0] aw_ret);
        logic [79:0] w;
        w = '0;
        w[79] = 1'b1; w[78:77] = typ; w[75:74] = resp; w[71:40] = data;
        w[7:4] = ar_ret; w[3:0] = aw_ret;
`ifdef AIB_AXI_LEADER_PARITY_EN
        w[76] = ^w;
`endif
        return w;
    endfunction

    // One cycle of the reference model, evaluated with this cycle's inputs.
    task automatic step();
        logic gate, gw, gr, bpop, rpop, send, pok, bfull, rfull;
        logic [79:0] w;
        int ret_aw, ret_ar, naw, nar;
        if (rst_wr) begin
            model_reset();
            chk("rst_tx", tx_phy0, '0);
            chk("rst_awready", uif.user_awready, 1'b0);
            chk("rst_arready", uif.user_arready, 1'b0);
            chk("rst_bvalid", uif.user_bvalid, 1'b0);
            chk("rst_rvalid", uif.user_rvalid, 1'b0);
            chk("rst_proto_err", proto_err, 1'b0);
            chk("rst_parity_err", parity_err, 1'b0);
            txq.push_back('0);
            return;
        end
        chk("proto_err", proto_err, m_perr);
        chk("parity_err", parity_err, m_parerr);
        gate = m_on && tx_online;
        gw = gate && uif.user_awvalid && uif.user_wvalid && m_aw > 0;
        gr = gate && uif.user_arvalid && m_ar > 0;
        if (gw && gr) begin
            gw = m_prio_wr; gr = !m_prio_wr;
        end
        chk("awready", uif.user_awready, gw);
        chk("wready", uif.user_wready, gw);
        chk("arready", uif.user_arready, gr);
        chk("bvalid", uif.user_bvalid, bq.size() > 0);
        if (bq.size() > 0) chk("bresp", uif.user_bresp, bq[0]);
        chk("rvalid", uif.user_rvalid, rq.size() > 0);
        if (rq.size() > 0) chk("rdata", {uif.user_rdata, uif.user_rresp}, rq[0]);
        bpop = bq.size() > 0 && uif.user_bready;
        rpop = rq.size() > 0 && uif.user_rready;

        send = gw || gr || (gate && (m_racc != 0 || m_bacc != 0));
        w = '0;
        if (send) begin
            w[79] = 1'b1;
            w[78:77] = gw ? 2'b01 : (gr ? 2'b10 : 2'b00);
            w[7:4] = 4'(m_racc);
            w[3:0] = 4'(m_bacc);
            if (gw) begin
                w[75:72] = uif.user_wstrb; w[71:40] = uif.user_awaddr; w[39:8] = uif.user_wdata;
            end
            if (gr) w[71:40] = uif.user_araddr;
`ifdef AIB_AXI_LEADER_PARITY_EN
            w[76] = ^w;
`endif
        end
        txq.push_back(w);

        bfull = bq.size() >= DEPTH;
        rfull = rq.size() >= DEPTH;
        if (bpop) void'(bq.pop_front());
        if (rpop) void'(rq.pop_front());

        ret_aw = 0; ret_ar = 0;
        if (m_on && rx_phy0[79]) begin
            pok = 1'b1;
`ifdef AIB_AXI_LEADER_PARITY_EN
            pok = ~^rx_phy0;
`endif
            if (!pok) m_parerr = 1'b1;
            else begin
                ret_aw = int'(rx_phy0[3:0]);
                ret_ar = int'(rx_phy0[7:4]);
                case (rx_phy0[78:77])
                    2'b01: if (bfull) m_perr = 1'b1; else bq.push_back(rx_phy0[75:74]);
                    2'b10: if (rfull) m_perr = 1'b1; else rq.push_back({rx_phy0[71:40], rx_phy0[75:74]});
                    2'b11: m_perr = 1'b1;
                    default: ;
                endcase
            end
        end

        if (send) begin
            m_racc = int'(rpop); m_bacc = int'(bpop);
        end else begin
            m_racc += int'(rpop); m_bacc += int'(bpop);
        end

        if (m_on) begin
            naw = m_aw - int'(gw) + ret_aw;
            nar = m_ar - int'(gr) + ret_ar;
            if (naw > int'(init_aw_credit)) begin naw = int'(init_aw_credit); m_perr = 1'b1; end
            if (nar > int'(init_ar_credit)) begin nar = int'(init_ar_credit); m_perr = 1'b1; end
            m_aw = naw; m_ar = nar;
        end else begin
            m_aw = int'(init_aw_credit); m_ar = int'(init_ar_credit);
            m_racc = 0; m_bacc = 0;
            bq.delete(); rq.delete();
        end
        if (gw) m_prio_wr = 1'b0;
        else if (gr) m_prio_wr = 1'b1;
        owed_aw += int'(gw); owed_b += int'(gw);
        owed_ar += int'(gr); owed_r += int'(gr);
        m_on = tx_online && rx_online;
    endtask

    // Monitor: compares every registered tx word against the scoreboard.
    initial begin
        forever begin
            @(posedge clk_wr);
            #1;
            if (txq.size() > 0) chk("tx_phy0", tx_phy0, txq.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic go();
        #1;
        step();
        @(posedge clk_wr);
        #2;
    endtask

    task automatic quiet();
        uif.user_awvalid = 0; uif.user_wvalid = 0; uif.user_arvalid = 0;
        rx_phy0 = '0;
    endtask

    task automatic do_reset(input logic [7:0] aw, input logic [7:0] ar);
        init_aw_credit = aw; init_ar_credit = ar;
        tx_online = 1; rx_online = 1;
        quiet();
        rst_wr = 1; go(); go();
        rst_wr = 0; go();
    endtask

    task automatic wr_req();
        uif.user_awvalid = 1; uif.user_wvalid = 1;
        uif.user_awaddr = $urandom; uif.user_wdata = $urandom; uif.user_wstrb = 4'($urandom);
    endtask

    initial begin
        logic [79:0] w;
        logic [1:0]  typ;
        int a, r;
        rst_wr = 1; tx_online = 0; rx_online = 0;
        init_aw_credit = 0; init_ar_credit = 0;
        uif.user_awaddr = 0; uif.user_wdata = 0; uif.user_wstrb = 0; uif.user_araddr = 0;
        uif.user_bready = 1; uif.user_rready = 1;
        quiet();
        model_reset();
        @(posedge clk_wr);
        #2;

        // two credits, three writes: third waits for a credit return
        do_reset(8'd2, 8'd2);
        for (int i = 0; i < 4; i++) begin wr_req(); go(); end
        rx_phy0 = rxw(2'b00, 2'b00, 32'h0, 4'd0, 4'd1); go();
        rx_phy0 = '0; go();
        quiet(); go(); go();

        // both sides always requesting: strict alternation starting with write
        do_reset(8'd8, 8'd8);
        for (int i = 0; i < 6; i++) begin
            wr_req(); uif.user_arvalid = 1; uif.user_araddr = $urandom; go();
        end
        quiet(); go();

        // two R responses returned in order while rready toggles
        do_reset(8'd2, 8'd2);
        uif.user_rready = 0;
        rx_phy0 = rxw(2'b10, 2'b00, 32'hA5A5A5A5, 4'd0, 4'd0); go();
        rx_phy0 = rxw(2'b10, 2'b01, 32'h5A5A5A5A, 4'd0, 4'd0); go();
        rx_phy0 = '0;
        uif.user_rready = 1; go();
        uif.user_rready = 0; go();
        uif.user_rready = 1; go(); go(); go();

        // B FIFO overflow with bready low
        do_reset(8'd2, 8'd2);
        uif.user_bready = 0;
        for (int i = 0; i < 5; i++) begin
            rx_phy0 = rxw(2'b01, 2'($urandom), 32'h0, 4'd0, 4'd0); go();
        end
        rx_phy0 = '0; go(); go();
        chk("bfifo_overflow_proto_err", proto_err, 1'b1);
        uif.user_bready = 1;
        for (int i = 0; i < 5; i++) go();
        chk("proto_err_sticky", proto_err, 1'b1);

        // tx_online drops mid-burst; credits back at init on recovery
        do_reset(8'd3, 8'd3);
        wr_req(); go(); wr_req(); go();
        tx_online = 0; wr_req(); go(); go(); go();
        tx_online = 1; go();
        for (int i = 0; i < 4; i++) begin wr_req(); go(); end
        quiet(); go();

        // corrupted bit 40 in an R word
        do_reset(8'd2, 8'd2);
        uif.user_rready = 0;
        w = rxw(2'b10, 2'b00, 32'h12345678, 4'd0, 4'd0);
        w[40] = ~w[40];
        rx_phy0 = w; go();
        rx_phy0 = '0; go();
`ifdef AIB_AXI_LEADER_PARITY_EN
        chk("parity_drop_rvalid", uif.user_rvalid, 1'b0);
        chk("parity_err_set", parity_err, 1'b1);
`else
        chk("noparity_accept_rvalid", uif.user_rvalid, 1'b1);
        chk("noparity_err_clear", parity_err, 1'b0);
`endif
        uif.user_rready = 1; go(); go();

        // type 11: dropped with proto_err, but its credit return still counts
        do_reset(8'd2, 8'd2);
        wr_req(); go(); wr_req(); go();
        quiet();
        rx_phy0 = rxw(2'b11, 2'b00, 32'h0, 4'd0, 4'd1); go();
        rx_phy0 = '0; go();
        chk("type11_proto_err", proto_err, 1'b1);
        wr_req(); go(); go();
        quiet(); go();

        // credit over-return saturates at init
        do_reset(8'd2, 8'd2);
        rx_phy0 = rxw(2'b00, 2'b00, 32'h0, 4'd0, 4'd1); go();
        rx_phy0 = '0; go();
        chk("saturate_proto_err", proto_err, 1'b1);
        for (int i = 0; i < 3; i++) begin wr_req(); go(); end
        quiet(); go();

        // randomized traffic with a follower that returns only owed credits
        do_reset(8'd3, 8'd2);
        for (int c = 0; c < 600; c++) begin
            if (c == 300 || c == 301) begin
                rst_wr = 1; quiet(); go();
                continue;
            end
            rst_wr = 0;
            uif.user_awvalid = 1'($urandom); uif.user_wvalid = 1'($urandom);
            uif.user_arvalid = 1'($urandom);
            uif.user_awaddr = $urandom; uif.user_wdata = $urandom;
            uif.user_wstrb = 4'($urandom); uif.user_araddr = $urandom;
            uif.user_bready = ($urandom_range(0, 3) != 0);
            uif.user_rready = ($urandom_range(0, 3) != 0);
            if (m_on && $urandom_range(0, 9) < 4) begin
                typ = 2'b00;
                if (owed_b > 0 && $urandom_range(0, 1) == 1) begin typ = 2'b01; owed_b--; end
                else if (owed_r > 0 && $urandom_range(0, 1) == 1) begin typ = 2'b10; owed_r--; end
                a = $urandom_range(0, (owed_aw > 3) ? 3 : owed_aw); owed_aw -= a;
                r = $urandom_range(0, (owed_ar > 3) ? 3 : owed_ar); owed_ar -= r;
                rx_phy0 = rxw(typ, 2'($urandom), $urandom, 4'(r), 4'(a));
            end else begin
                w = {$urandom, $urandom, $urandom};
                w[79] = 1'b0;
                rx_phy0 = w;
            end
            go();
        end
        quiet(); go(); go();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/aib_axi_lite_leader_link.md
AIB_AXI_LITE_LEADER_LINK -- requirements
Module: aib_axi_lite_leader_link

Interface
REQ-001 SHALL have parameter RSP_DEPTH, default 4, setting the R and B response FIFO depth (power of 2, ≤8).
REQ-002 SHALL have clk_wr, input, 1: the single clock for all logic.
REQ-003 SHALL have rst_wr, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have tx_online and rx_online, input, 1 each: the PHY link is up in that direction.
REQ-005 SHALL have init_aw_credit and init_ar_credit, input, 8 each: credits granted by the follower.
REQ-006 SHALL have user_aw{addr[31:0],valid,ready}, user_w{data[31:0],strb[3:0],valid,ready} and user_ar{addr[31:0],valid,ready}: AXI-Lite slave request ports.
REQ-007 SHALL have user_b{resp[1:0],valid,ready} and user_r{data[31:0],resp[1:0],valid,ready}: AXI-Lite slave response ports.
REQ-008 SHALL have tx_phy0, output, 80 (registered), and rx_phy0, input, 80.
REQ-009 SHALL have proto_err and parity_err, output, 1 each, both sticky.

Function
REQ-010 tx word: [79] vld; [78:77] type (01 write, 10 read, 00 credit-only); [76] parity; [75:72] wstrb; [71:40] addr; [39:8] wdata; [7:4] R-credit return; [3:0] B-credit return. Unused fields SHALL be 0, and an idle word SHALL be all-zero.
REQ-011 rx word: [79] vld; [78:77] type (01 B, 10 R, 00 credit-only); [76] parity; [75:74] resp; [71:40] rdata; [7:4] AR-credit return; [3:0] AW-credit return.
REQ-012 Write issue SHALL require user_awvalid & user_wvalid & aw_cnt>0 & tx_online; user_awready and user_wready SHALL assert together in that cycle only.
REQ-013 Read issue SHALL require user_arvalid & ar_cnt>0 & tx_online.
REQ-014 At most one request SHALL issue per cycle. When both are eligible, the arbiter SHALL round-robin: the state tracks the last grant, and after reset the write side has priority.
REQ-015 An issued request SHALL appear on tx_phy0 exactly 1 cycle after the handshake cycle.
REQ-016 The issuing credit counter SHALL decrement by 1; rx credit returns SHALL add to aw_cnt/ar_cnt in the cycle received. Simultaneous issue and return SHALL net out.
REQ-017 A credit counter exceeding its init value SHALL saturate at init and set proto_err.
REQ-018 A received B or R word SHALL push the B or R FIFO. A push to a full FIFO SHALL drop the word and set proto_err.
REQ-019 user_bvalid/user_rvalid SHALL be FIFO non-empty. The FIFO SHALL pop on valid & ready, and the head SHALL present combinationally.
REQ-020 Each pop SHALL increment a 4-bit pending-return accumulator (R or B). Every tx word SHALL carry and clear the accumulator; a simultaneous pop SHALL be counted into the next word.
REQ-021 If no request issues and an accumulator is nonzero, the block SHALL send a credit-only word (vld=1, type=00).
REQ-022 Link state machine:
  - OFFLINE -> ONLINE when tx_online & rx_online.
  - ONLINE -> OFFLINE when either input drops.
REQ-023 In OFFLINE:
  - Counters SHALL reload from init_*_credit.
  - No issue; tx_phy0 = 0; rx_phy0 ignored.
  - FIFOs and accumulators SHALL clear.
  - Sticky errors SHALL persist.
REQ-024 rx words SHALL be ignored when rx_phy0[79]=0. Type 11 SHALL set proto_err and be dropped, except that its credit fields SHALL still be applied.

Reset
REQ-025 On rst_wr:
  - State = OFFLINE; arbiter points to write.
  - Counters = 0; FIFOs empty; accumulators 0.
  - tx_phy0 = 0; all ready/valid outputs 0; proto_err = 0; parity_err = 0.
REQ-026 Reset asserted mid-transfer SHALL discard all in-flight state with no partial tx word.

Configuration
REQ-027 Macro AIB_AXI_LEADER_PARITY_EN defined:
  - tx[76] SHALL be even parity over tx[79:77,75:0].
  - rx words with bad parity SHALL be dropped entirely, including their credits, and set parity_err.
REQ-028 AIB_AXI_LEADER_PARITY_EN undefined:
  - tx[76] = 0; rx[76] ignored.
  - parity_err tied 0.

Verification
REQ-029 init_aw_credit=2, rx silent, 3 back-to-back writes -> 2 tx write words on consecutive cycles, 3rd stalls (awready=0). Then rx credit-only word with [3:0]=1 -> 3rd issues next cycle.
REQ-030 awvalid, wvalid and arvalid held continuously, ample credits -> tx types alternate 01,10,01,10 starting with write.
REQ-031 Two rx R words (rdata 0xA5A5A5A5, 0x5A5A5A5A), rready toggled -> returned in order. Pops produce R-credit returns totalling 2 in subsequent tx words, carried in credit-only words if idle.
REQ-032 rx B pushed into a full B FIFO (RSP_DEPTH=4, bready=0) -> word dropped, proto_err=1 and stays set.
REQ-033 tx_online dropped mid-burst -> tx_phy0=0 next cycle. On recovery, counters equal init values.
REQ-034 With AIB_AXI_LEADER_PARITY_EN, rx word with flipped bit 40 -> dropped, parity_err=1. Without the macro -> word accepted.
